// File: rtl/rv_iopmp_cfg_sequencer_if.sv
// Command stream and register-interface bus between the IOPMP config sequencer and its environment.
// The master modport is the sequencer side; the slave modport is the command source / register responder side.
interface rv_iopmp_cfg_sequencer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [1:0]            cmd_op_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [DATA_WIDTH-1:0] cmd_data_i;
    logic [DATA_WIDTH-1:0] cmd_mask_i;

    logic                  reg_valid_o;
    logic                  reg_write_o;
    logic [ADDR_WIDTH-1:0] reg_addr_o;
    logic [DATA_WIDTH-1:0] reg_wdata_o;
    logic [3:0]            reg_wstrb_o;
    logic                  reg_ready_i;
    logic [DATA_WIDTH-1:0] reg_rdata_i;
    logic                  reg_error_i;

    modport master (
        input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, cmd_mask_i,
        input  reg_ready_i, reg_rdata_i, reg_error_i,
        output cmd_ready_o,
        output reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o
    );

    modport slave (
        output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, cmd_mask_i,
        output reg_ready_i, reg_rdata_i, reg_error_i,
        input  cmd_ready_o,
        input  reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o
    );
endinterface

// File: rtl/rv_iopmp_cfg_sequencer.sv
// Replays WRITE/POLL/END commands as register-bus transactions; optional write readback under RV_IOPMP_CFG_SEQ_READBACK_EN.
// Latency: WRITE 2 cycles (4 with readback), POLL 2 per attempt; a request waits on reg_ready_i up to TIMEOUT_CYCLES.
module rv_iopmp_cfg_sequencer #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int POLL_LIMIT     = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    rv_iopmp_cfg_sequencer_if.master    bus,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic [2:0]                  err_code_o,
    output logic [15:0]                 err_idx_o
);
`ifdef RV_IOPMP_CFG_SEQ_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_POLL  = 2'd1;
    localparam logic [1:0] OP_END   = 2'd2;

    localparam logic [2:0] ERR_BUS      = 3'd1;
    localparam logic [2:0] ERR_POLL     = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
    localparam logic [2:0] ERR_OP       = 3'd4;
    localparam logic [2:0] ERR_READBACK = 3'd5;

    typedef enum logic [2:0] {IDLE, FETCH, ACCESS, CHECK, DONE, ERROR} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q, mask_q, rdata_q;
    logic                  wr_q, rb_q;
    logic [31:0]           attempts_q, tcnt_q;
    logic [15:0]           idx_q;
    logic                  done_q, error_q;
    logic [2:0]            err_code_q;
    logic [15:0]           err_idx_q;

    logic                  fail, advance, finish;
    logic [2:0]            fail_code;
    logic                  match, retry, timeout;

    assign match   = ((rdata_q ^ data_q) & mask_q) == '0;
    assign retry   = attempts_q < 32'(POLL_LIMIT);
    assign timeout = tcnt_q == 32'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        fail            = 1'b0;
        fail_code       = 3'd0;
        advance         = 1'b0;
        finish          = 1'b0;
        bus.cmd_ready_o = 1'b0;
        bus.reg_valid_o = 1'b0;
        bus.reg_write_o = 1'b0;
        bus.reg_addr_o  = '0;
        bus.reg_wdata_o = '0;
        bus.reg_wstrb_o = 4'h0;
        busy_o          = 1'b0;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start_i) state_d = FETCH;
            end
            FETCH: begin
                busy_o          = 1'b1;
                bus.cmd_ready_o = 1'b1;
                if (bus.cmd_valid_i) begin
                    case (bus.cmd_op_i)
                        OP_WRITE, OP_POLL: state_d = ACCESS;
                        OP_END: begin
                            state_d = DONE;
                            finish  = 1'b1;
                        end
                        default: begin
                            state_d   = ERROR;
                            fail      = 1'b1;
                            fail_code = ERR_OP;
                        end
                    endcase
                end
            end
            ACCESS: begin
                busy_o          = 1'b1;
                bus.reg_valid_o = 1'b1;
                bus.reg_write_o = wr_q;
                bus.reg_addr_o  = addr_q;
                bus.reg_wdata_o = wr_q ? data_q : '0;
                bus.reg_wstrb_o = wr_q ? 4'hF : 4'h0;
                if (bus.reg_ready_i) begin
                    if (bus.reg_error_i) begin
                        state_d   = ERROR;
                        fail      = 1'b1;
                        fail_code = ERR_BUS;
                    end else if (wr_q) begin
                        // With readback the same ACCESS state reissues as a read of the written address.
                        state_d = READBACK ? ACCESS : FETCH;
                        advance = !READBACK;
                    end else begin
                        state_d = CHECK;
                    end
                end else if (timeout) begin
                    state_d   = ERROR;
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            CHECK: begin
                busy_o = 1'b1;
                if (match) begin
                    state_d = FETCH;
                    advance = 1'b1;
                end else if (rb_q) begin
                    state_d   = ERROR;
                    fail      = 1'b1;
                    fail_code = ERR_READBACK;
                end else if (retry) begin
                    state_d = ACCESS;
                end else begin
                    state_d   = ERROR;
                    fail      = 1'b1;
                    fail_code = ERR_POLL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            rdata_q    <= '0;
            wr_q       <= 1'b0;
            rb_q       <= 1'b0;
            attempts_q <= '0;
            tcnt_q     <= '0;
            idx_q      <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= '0;
            err_idx_q  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start_i) begin
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        err_code_q <= '0;
                        err_idx_q  <= '0;
                        idx_q      <= '0;
                    end
                end
                FETCH: begin
                    if (bus.cmd_valid_i) begin
                        addr_q     <= bus.cmd_addr_i;
                        data_q     <= bus.cmd_data_i;
                        mask_q     <= bus.cmd_mask_i;
                        wr_q       <= bus.cmd_op_i == OP_WRITE;
                        rb_q       <= 1'b0;
                        attempts_q <= 32'd1;
                        tcnt_q     <= '0;
                    end
                end
                ACCESS: begin
                    if (bus.reg_ready_i) begin
                        tcnt_q <= '0;
                        if (!bus.reg_error_i && wr_q && READBACK) begin
                            wr_q   <= 1'b0;
                            rb_q   <= 1'b1;
                            mask_q <= '1;
                        end
                        if (!wr_q) rdata_q <= bus.reg_rdata_i;
                    end else begin
                        tcnt_q <= tcnt_q + 32'd1;
                    end
                end
                CHECK: begin
                    if (!match && !rb_q && retry) attempts_q <= attempts_q + 32'd1;
                end
                default: ;
            endcase
            if (advance) idx_q <= idx_q + 16'd1;
            if (finish)  done_q <= 1'b1;
            if (fail) begin
                error_q    <= 1'b1;
                err_code_q <= fail_code;
                err_idx_q  <= idx_q;
            end
        end
    end

    assign done_o     = done_q;
    assign error_o    = error_q;
    assign err_code_o = err_code_q;
    assign err_idx_o  = err_idx_q;
endmodule

// File: tb/tb_rv_iopmp_cfg_sequencer.sv
// Directed bench for rv_iopmp_cfg_sequencer: command table source plus a scripted register responder.
module tb_rv_iopmp_cfg_sequencer;
`ifdef RV_IOPMP_CFG_SEQ_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start;
    logic        busy, done, error;
    logic [2:0]  err_code;
    logic [15:0] err_idx;

    always #5 clk = ~clk;

    rv_iopmp_cfg_sequencer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    rv_iopmp_cfg_sequencer #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .POLL_LIMIT(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .bus(bus),
        .busy_o(busy), .done_o(done), .error_o(error),
        .err_code_o(err_code), .err_idx_o(err_idx)
    );

    int          tests = 0;
    int          fails = 0;
    logic [1:0]  c_op   [8];
    logic [31:0] c_addr [8];
    logic [31:0] c_data [8];
    logic [31:0] c_mask [8];
    logic [31:0] rd_vals[8];
    int          ncmd, cmd_ptr, rd_idx, wr_count, vld_cycles, rdy_cycles, bad_strb, err_wr, n, r0;
    logic [31:0] last_waddr, last_wdata, rb_xor;
    logic        rsp_ready, rb_pending;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setcmd(input int i, input logic [1:0] op, input logic [31:0] a, d, m);
        c_op[i] = op; c_addr[i] = a; c_data[i] = d; c_mask[i] = m;
    endtask

    task automatic clr();
        ncmd = 0; cmd_ptr = 0; rd_idx = 0; wr_count = 0; vld_cycles = 0; rdy_cycles = 0;
        bad_strb = 0; err_wr = 99; rsp_ready = 1'b1; rb_pending = 1'b0; rb_xor = '0;
        last_waddr = '0; last_wdata = '0;
        for (int i = 0; i < 8; i++) begin
            rd_vals[i] = '0;
            setcmd(i, 2'd2, '0, '0, '0);
        end
    endtask

    // Drive inputs from the settled DUT outputs, log the handshakes that the next edge completes, then advance.
    task automatic cyc();
        int k;
        int r;
        k = (cmd_ptr < 8) ? cmd_ptr : 7;
        r = (rd_idx < 8) ? rd_idx : 7;
        bus.cmd_valid_i = cmd_ptr < ncmd;
        bus.cmd_op_i    = c_op[k];
        bus.cmd_addr_i  = c_addr[k];
        bus.cmd_data_i  = c_data[k];
        bus.cmd_mask_i  = c_mask[k];
        bus.reg_ready_i = rsp_ready;
        bus.reg_rdata_i = rb_pending ? (last_wdata ^ rb_xor) : rd_vals[r];
        bus.reg_error_i = bus.reg_valid_o && bus.reg_write_o && (wr_count == err_wr);
        if (bus.reg_valid_o) vld_cycles++;
        if (bus.cmd_ready_o) rdy_cycles++;
        if (bus.reg_valid_o && bus.reg_ready_i) begin
            if (bus.reg_write_o) begin
                if (bus.reg_wstrb_o != 4'hF) bad_strb++;
                last_waddr = bus.reg_addr_o;
                last_wdata = bus.reg_wdata_o;
                wr_count++;
                if (RB && !bus.reg_error_i) rb_pending = 1'b1;
            end else begin
                if (bus.reg_wstrb_o != 4'h0) bad_strb++;
                if (rb_pending) rb_pending = 1'b0;
                else rd_idx++;
            end
        end
        if (bus.cmd_valid_i && bus.cmd_ready_o) cmd_ptr++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int pulse_at, output int cycles);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("cmd_ready_after_start", bus.cmd_ready_o, 1);
        cycles = 0;
        while (busy && cycles < 200) begin
            start = (cycles == pulse_at);
            cyc();
            cycles++;
        end
        start = 1'b0;
        chk("run_budget", cycles < 200, 1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        clr();
        repeat (3) cyc();
        chk("rst_cmd_ready", bus.cmd_ready_o, 0);
        chk("rst_reg_valid", bus.reg_valid_o, 0);
        chk("rst_status", {busy, done, error, err_code}, 0);
        rst = 1'b0;
        cyc();

        // Two writes then END.
        clr();
        setcmd(0, 2'd0, 32'h0004, 32'h1, 32'h0);
        setcmd(1, 2'd0, 32'h1000, 32'hA5, 32'h0);
        ncmd = 3;
        run(-1, n);
        chk("wr_cycles", n, RB ? 9 : 5);
        chk("wr_count", wr_count, 2);
        chk("wr_strb", bad_strb, 0);
        chk("wr_last_addr", last_waddr, 32'h1000);
        chk("wr_last_data", last_wdata, 32'hA5);
        chk("wr_done_busy_err", {done, busy, error}, 3'b100);

        // Poll that matches on the third read.
        clr();
        setcmd(0, 2'd1, 32'h0, 32'h1, 32'h1);
        ncmd = 2;
        rd_vals[2] = 32'h1;
        run(-1, n);
        chk("poll_reads", rd_idx, 3);
        chk("poll_cycles", n, 8);
        chk("poll_next_fetched", cmd_ptr, 2);
        chk("poll_done_err", {done, error}, 2'b10);

        // Poll that never matches: limit of 4 attempts.
        clr();
        setcmd(0, 2'd0, 32'h10, 32'h7, 32'h0);
        setcmd(1, 2'd1, 32'h20, 32'h5, 32'hF);
        ncmd = 3;
        run(-1, n);
        chk("plim_reads", rd_idx, 4);
        chk("plim_cycles", n, RB ? 13 : 11);
        chk("plim_code", err_code, 2);
        chk("plim_idx", err_idx, 1);
        chk("plim_done_err", {done, error}, 2'b01);

        // Bus error on the third command.
        clr();
        setcmd(0, 2'd0, 32'h0, 32'h1, 32'h0);
        setcmd(1, 2'd0, 32'h4, 32'h2, 32'h0);
        setcmd(2, 2'd0, 32'h8, 32'h3, 32'h0);
        ncmd = 4;
        err_wr = 2;
        run(-1, n);
        chk("buserr_code", err_code, 1);
        chk("buserr_idx", err_idx, 2);
        chk("buserr_flag", error, 1);
        r0 = rdy_cycles;
        repeat (4) cyc();
        chk("buserr_no_ready", rdy_cycles - r0, 0);
        chk("buserr_cmd_ptr", cmd_ptr, 3);

        // Reserved op.
        clr();
        setcmd(0, 2'd0, 32'h40, 32'h9, 32'h0);
        setcmd(1, 2'd3, 32'h0, 32'h0, 32'h0);
        ncmd = 3;
        run(-1, n);
        chk("badop_code", err_code, 4);
        chk("badop_idx", err_idx, 1);

        // Readback returns 0xA4 for a write of 0xA5.
        clr();
        setcmd(0, 2'd0, 32'h1000, 32'hA5, 32'h0);
        ncmd = 2;
        rb_xor = 32'h1;
        run(-1, n);
        chk("rb_code", err_code, RB ? 5 : 0);
        chk("rb_done_err", {done, error}, RB ? 2'b01 : 2'b10);

        // Responder never ready; a start pulse while busy must be ignored.
        clr();
        setcmd(0, 2'd0, 32'h30, 32'h1, 32'h0);
        ncmd = 2;
        rsp_ready = 1'b0;
        run(3, n);
        chk("tmo_valid_cycles", vld_cycles, 8);
        chk("tmo_code", err_code, 3);
        chk("tmo_idx", err_idx, 0);
        chk("tmo_valid_dropped", bus.reg_valid_o, 0);

        // Reset while a request is outstanding.
        clr();
        setcmd(0, 2'd0, 32'h30, 32'h55, 32'h0);
        ncmd = 2;
        rsp_ready = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        chk("midwait_valid", bus.reg_valid_o, 1);
        chk("midwait_addr", bus.reg_addr_o, 32'h30);
        chk("midwait_wdata", bus.reg_wdata_o, 32'h55);
        rst = 1'b1;
        cyc();
        chk("rst2_reg_ctl", {bus.reg_valid_o, bus.reg_write_o, bus.reg_wstrb_o, bus.cmd_ready_o}, 0);
        chk("rst2_reg_addr", bus.reg_addr_o, 0);
        chk("rst2_reg_wdata", bus.reg_wdata_o, 0);
        chk("rst2_status", {busy, done, error, err_code, err_idx}, 0);
        rst = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rv_iopmp_cfg_sequencer.md
# rv_iopmp_cfg_sequencer

Register-interface initiator that programs the IOPMP register map without software. It consumes a stream of configuration commands (write, masked poll, end), issues them one at a time as register-interface transactions toward the IOPMP register-map responder, and reports completion or the first failure. It sits in front of the IOPMP configuration path, muxed with the AXI configuration abstractor, so boot-time MDCFG/SRCMD/entry tables can be loaded from a ROM or FIFO.

## Interface

Parameters:
- `ADDR_WIDTH`, default 32: register address width.
- `DATA_WIDTH`, default 32: register data width; must be 32.
- `POLL_LIMIT`, default 16: maximum read attempts per POLL command; must be ≥1.
- `TIMEOUT_CYCLES`, default 256: maximum cycles `reg_valid_o` may wait for `reg_ready_i`; must be ≥1.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: single-cycle pulse that starts a sequence.
- `cmd_valid_i` in 1: command available.
- `cmd_ready_o` out 1: command accepted when high together with `cmd_valid_i`.
- `cmd_op_i` in 2: 0 WRITE, 1 POLL, 2 END, 3 reserved.
- `cmd_addr_i` in ADDR_WIDTH: target register address.
- `cmd_data_i` in 32: write data, or poll expected value.
- `cmd_mask_i` in 32: poll compare mask (ignored for WRITE).
- `reg_valid_o` out 1: register request valid.
- `reg_write_o` out 1: 1 = write, 0 = read.
- `reg_addr_o` out ADDR_WIDTH: request address.
- `reg_wdata_o` out 32: write data.
- `reg_wstrb_o` out 4: byte strobes, always 4'hF for writes, 4'h0 for reads.
- `reg_ready_i` in 1: responder completes the request this cycle.
- `reg_rdata_i` in 32: read data, valid when `reg_valid_o && reg_ready_i`.
- `reg_error_i` in 1: access error, valid when `reg_valid_o && reg_ready_i`.
- `busy_o` out 1: sequence in progress.
- `done_o` out 1: last sequence ended with END and no error.
- `error_o` out 1: last sequence aborted.
- `err_code_o` out 3: 0 none, 1 bus error, 2 poll limit, 3 timeout, 4 bad op, 5 readback mismatch.
- `err_idx_o` out 16: zero-based index of the failing command.

## Operation

- States: IDLE, FETCH, ACCESS, CHECK, DONE, ERROR.
- IDLE: `start_i` goes to FETCH, clears the status outputs, and sets the command index to 0.
- FETCH: `cmd_ready_o` is high.
  - On a handshake the command is latched and the block goes to ACCESS.
  - END goes to DONE.
  - A reserved op goes to ERROR with code 4.
- ACCESS: `reg_valid_o` is high. Address, write, data and strobe stay stable until `reg_ready_i`.
  - At completion, `reg_error_i` goes to ERROR with code 1.
  - A completed WRITE increments the index and returns to FETCH.
  - A completed POLL read goes to CHECK with `reg_rdata_i` latched.
- CHECK (one cycle): compare `(rdata & mask) == (data & mask)`.
  - On a match, increment the index and go to FETCH.
  - On a miss with attempts < POLL_LIMIT, go back to ACCESS and reissue the read.
  - Otherwise go to ERROR with code 2.
- Timeout counter: reset on entering ACCESS, counts each cycle of `reg_valid_o && !reg_ready_i`. Reaching TIMEOUT_CYCLES goes to ERROR with code 3 and drops `reg_valid_o` in the following cycle.
- DONE and ERROR hold their status. `start_i` in either state behaves as in IDLE.
- `start_i` is ignored while `busy_o` is high.
- `busy_o` is high in FETCH, ACCESS and CHECK.
- The command index wraps at 2^16.

## Timing

- Reset values: state IDLE; `cmd_ready_o`, `reg_valid_o`, `reg_write_o`, `busy_o`, `done_o` and `error_o` are 0; all buses are 0.
- `start_i` in cycle N: `cmd_ready_o` is high in cycle N+1.
- Command handshake in cycle N: `reg_valid_o` is high in cycle N+1. With a zero-wait responder, the next `cmd_ready_o` is high in cycle N+2, so a WRITE costs 2 cycles.
- A POLL attempt costs 2 cycles plus wait states (ACCESS, then CHECK).
- `done_o` and `error_o` are registered and rise the cycle after the terminating event.
- `err_code_o` and `err_idx_o` change in the same cycle as `error_o`.
- Reset asserted mid-transaction: the next cycle matches the reset values. An outstanding request is abandoned.

## Configuration

- `RV_IOPMP_CFG_SEQ_READBACK_EN` defined:
  - Every completed WRITE without error is followed by a read of the same address (ACCESS, then CHECK, single attempt, full mask against the written data).
  - A mismatch goes to ERROR with code 5.
  - A WRITE costs 4 cycles with zero wait.
- Undefined: writes are fire-and-forget. Code 5 is never produced.

## Test plan

- Reset then `start_i`; commands WRITE 0x0004=0x1, WRITE 0x1000=0xA5, END; responder always ready, no error:
  - exactly two writes appear with strobe 4'hF.
  - `done_o`=1 and `busy_o`=0.
- POLL addr 0x0000, data 0x1, mask 0x1; responder returns 0x0 twice, then 0x1:
  - three reads are issued.
  - the next command is fetched and no error is raised.
- POLL with POLL_LIMIT=4 and data never matching:
  - exactly 4 reads are issued.
  - `error_o`=1, `err_code_o`=2, `err_idx_o` = index of the POLL command.
- Third command WRITE, responder returns `reg_error_i`=1:
  - `err_code_o`=1, `err_idx_o`=2.
  - no further `cmd_ready_o`.
- Responder never ready, TIMEOUT_CYCLES=8:
  - `reg_valid_o` is high for exactly 8 cycles.
  - `err_code_o`=3.
  - reset mid-wait returns all outputs to 0 in the next cycle.
- `RV_IOPMP_CFG_SEQ_READBACK_EN` defined; responder returns 0xA4 for a write of 0xA5:
  - `err_code_o`=5.
  - with the macro undefined, the same stimulus gives `done_o`=1.
